fp16_add_seq: RTL

Multi-cycle half-precision (1/5/10) adder/subtractor coprocessor.
- Computes A + B in the same format the fltflt program uses: bias 15, hidden bit = |exp.
- Sits beside the program-driven core. Operands are loaded from data memory bytes 128..131; the result is written back to bytes 132..133 by the core.
- Gives the hardware answer that the software float routine is scored against.

---
 rtl/fp16_add_if.sv | 12 +
 rtl/fp16_add_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fp16_add_if.sv
// Handshake and operand/result bundle for the half-precision adder coprocessor.
interface fp16_add_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;

  modport master (output start, a, b, input busy, done, result);
  modport slave  (input start, a, b, output busy, done, result);
endinterface

// File: rtl/fp16_add_seq.sv
// Multi-cycle 1/5/10 floating-point adder: bias 15, exp 0 means zero, no Inf/NaN,
// round to nearest even with G/R/S, saturating exponent overflow.
module fp16_add_seq #(
  parameter int MAX_ALIGN  = 13,
  parameter bit SAT_RESULT = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  fp16_add_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  localparam logic [4:0] MAX_ALIGN_W = 5'(MAX_ALIGN);

  state_t      state_reg;
  logic [13:0] big_reg;     // {hidden, frac[9:0], guard, round, sticky}
  logic [13:0] small_reg;
  logic [14:0] sum_reg;     // carry bit on top of the mantissa frame
  logic [5:0]  exp_reg;
  logic [4:0]  diff_reg;
  logic        sign_reg;
  logic        sign_a_reg;
  logic        sign_b_reg;
  logic        sub_reg;
  logic        zero_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [15:0] result_reg;

  logic        a_ge_b;
  logic [10:0] mant_a;
  logic [10:0] mant_b;
  logic        round_up;
  logic        mant_ovf;
  logic [9:0]  frac_r;
  logic [5:0]  exp_r;
  logic [15:0] rounded;

  assign a_ge_b = bus.a[14:10] > bus.b[14:10] ||
                  (bus.a[14:10] == bus.b[14:10] && bus.a[9:0] >= bus.b[9:0]);
  assign mant_a = (bus.a[14:10] != 5'd0) ? {1'b1, bus.a[9:0]} : 11'd0;
  assign mant_b = (bus.b[14:10] != 5'd0) ? {1'b1, bus.b[9:0]} : 11'd0;

  // Ties go to even: round up on G unless R, S and the kept LSB are all zero.
  assign round_up = sum_reg[2] & (sum_reg[1] | sum_reg[0] | sum_reg[3]);
  assign frac_r   = sum_reg[12:3] + {9'd0, round_up};
  assign mant_ovf = round_up & (&sum_reg[12:3]);
  assign exp_r    = mant_ovf ? exp_reg + 6'd1 : exp_reg;

  always_comb begin
    rounded = {sign_reg, exp_r[4:0], frac_r};
    if (zero_reg) begin
      rounded = {sign_reg, 15'd0};
    end else if (exp_r > 6'd31 && SAT_RESULT) begin
      rounded = {sign_reg, 5'h1F, 10'h3FF};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      big_reg    <= '0;
      small_reg  <= '0;
      sum_reg    <= '0;
      exp_reg    <= '0;
      diff_reg   <= '0;
      sign_reg   <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      sub_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            busy_reg   <= 1'b1;
            zero_reg   <= 1'b0;
            sign_a_reg <= bus.a[15];
            sign_b_reg <= bus.b[15];
            sub_reg    <= bus.a[15] ^ bus.b[15];
            if (a_ge_b) begin
              big_reg   <= {mant_a, 3'b000};
              small_reg <= {mant_b, 3'b000};
              exp_reg   <= {1'b0, bus.a[14:10]};
              diff_reg  <= bus.a[14:10] - bus.b[14:10];
              sign_reg  <= bus.a[15];
            end else begin
              big_reg   <= {mant_b, 3'b000};
              small_reg <= {mant_a, 3'b000};
              exp_reg   <= {1'b0, bus.b[14:10]};
              diff_reg  <= bus.b[14:10] - bus.a[14:10];
              sign_reg  <= bus.b[15];
            end
            state_reg <= ALIGN;
          end
        end
        ALIGN: begin
          if (diff_reg > MAX_ALIGN_W) begin
            small_reg <= {13'd0, |small_reg};
            state_reg <= ADD;
          end else if (diff_reg == 5'd0) begin
            state_reg <= ADD;
          end else begin
            small_reg <= {1'b0, small_reg[13:2], small_reg[1] | small_reg[0]};
            diff_reg  <= diff_reg - 5'd1;
            if (diff_reg == 5'd1) begin
              state_reg <= ADD;
            end
          end
        end
        ADD: begin
          sum_reg   <= sub_reg ? {1'b0, big_reg} - {1'b0, small_reg}
                               : {1'b0, big_reg} + {1'b0, small_reg};
          state_reg <= NORM;
        end
        NORM: begin
          if (sum_reg[14]) begin
            sum_reg   <= {1'b0, sum_reg[14:2], sum_reg[1] | sum_reg[0]};
            exp_reg   <= exp_reg + 6'd1;
            state_reg <= ROUND;
          end else if (sum_reg[13:0] == 14'd0) begin
            zero_reg  <= 1'b1;
            sign_reg  <= sign_a_reg & sign_b_reg;
            state_reg <= ROUND;
          end else if (sum_reg[13]) begin
            state_reg <= ROUND;
          end else begin
            sum_reg <= {sum_reg[13:0], 1'b0};
            exp_reg <= exp_reg - 6'd1;
            // Underflow below the smallest exponent flushes to a signed zero.
            if (exp_reg == 6'd1) begin
              zero_reg  <= 1'b1;
              state_reg <= ROUND;
            end
          end
        end
        ROUND: begin
          result_reg <= rounded;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
endmodule
